dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_PDU = 1'b1;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin priority decision: picks one eligible requester,
// favouring the one that was not granted last when both are asking.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  input  logic       last,
  output logic [1:0] grant
);

  logic [1:0] active;

  assign active = req & eligible;

  // One-hot grant; on a conflict the pointer hands the slot to the other side
  always_comb begin
    grant = 2'b00;
    if (active == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = active;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter sharing one single-cycle memory port between the CPU
// (requester 0) and the PDU (requester 1). Each access takes an accept
// cycle in IDLE and one ACCESS cycle; completion is signalled a cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_pdu,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .eligible ({1'b1, ~is_pdu}),
    .last     (last_grant),
    .grant    (grant)
  );

  // Accept only while idle and out of reset, so a held request cannot be
  // acknowledged before the first edge after reset release
  assign m0_ready = rst && (state == IDLE) && grant[0];
  assign m1_ready = rst && (state == IDLE) && grant[1];

  // Access sequencer: latch the winner in IDLE, perform the memory cycle in
  // ACCESS, and pulse the owner's done on the way back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= REQ_CPU;
      last_grant <= REQ_PDU;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[1]) begin
            owner      <= REQ_PDU;
            last_grant <= REQ_PDU;
            mem_we     <= m1_we;
            mem_addr   <= m1_addr;
            mem_wdata  <= m1_wdata;
            state      <= ACCESS;
          end else if (grant[0]) begin
            owner      <= REQ_CPU;
            last_grant <= REQ_CPU;
            mem_we     <= m0_we;
            mem_addr   <= m0_addr;
            mem_wdata  <= m0_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (owner == REQ_PDU) begin
            m1_done <= 1'b1;
            if (!mem_we) begin
              m1_rdata <= mem_rdata;
            end
          end else begin
            m0_done <= 1'b1;
            if (!mem_we) begin
              m0_rdata <= mem_rdata;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_pdu;
  logic        m0_req, m0_we, m0_ready, m0_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ready, m1_done;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .is_pdu    (is_pdu),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ready  (m0_ready),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ready  (m1_ready),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-addressed memory attached to the arbiter's port
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory write port, committed at the end of the write cycle
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Transaction-level reference model state
  logic [31:0] model_mem [0:255];
  bit          pend [2];
  bit          pend_we [2];
  logic [31:0] pend_addr [2];
  logic [31:0] pend_data [2];
  bit          keep [2];
  bit          rand_mode;
  int          cyc;
  bit          last;
  bit          have_txn;
  int          txn_id;
  bit          txn_we;
  logic [31:0] txn_addr, txn_data;
  bit          done_pend;
  int          done_cycle, done_id;
  bit          done_rd;
  logic [31:0] done_val;
  logic [31:0] exp_rdata [2];
  int          n_checks, n_fail;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_m0_ready"}, {31'b0, m0_ready}, 32'd0);
    check_output({tag, "_m1_ready"}, {31'b0, m1_ready}, 32'd0);
    check_output({tag, "_m0_done"}, {31'b0, m0_done}, 32'd0);
    check_output({tag, "_m1_done"}, {31'b0, m1_done}, 32'd0);
    check_output({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check_output({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  task automatic apply_stimulus(input int id, input bit we, input logic [31:0] addr, input logic [31:0] data);
    pend[id]      = 1'b1;
    pend_we[id]   = we;
    pend_addr[id] = addr;
    pend_data[id] = data;
  endtask

  task automatic new_request(input int id);
    logic [7:0] word;
    word = 8'($urandom_range(0, 255));
    apply_stimulus(id, 1'($urandom_range(0, 1)), {22'b0, word, 2'b00}, $urandom);
  endtask

  task automatic drive_inputs();
    m0_req   = pend[0];
    m0_we    = pend_we[0];
    m0_addr  = pend_addr[0];
    m0_wdata = pend_data[0];
    m1_req   = pend[1];
    m1_we    = pend_we[1];
    m1_addr  = pend_addr[1];
    m1_wdata = pend_data[1];
  endtask

  task automatic reset_model();
    have_txn     = 1'b0;
    done_pend    = 1'b0;
    last         = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    cyc          = 0;
  endtask

  // One clock cycle: drive, check against model, advance model, step clock
  task automatic run_cycle();
    int win;
    bit act0, act1;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && (keep[i] || (rand_mode && $urandom_range(0, 2) == 0))) new_request(i);
    end
    if (rand_mode && $urandom_range(0, 9) == 0) is_pdu = ~is_pdu;
    drive_inputs();
    #1;
    if (done_pend && cyc == done_cycle && done_rd) exp_rdata[done_id] = done_val;
    act0 = pend[0] && !is_pdu;
    act1 = pend[1];
    win  = -1;
    if (!have_txn) begin
      if (act0 && act1) win = last ? 0 : 1;
      else if (act0)    win = 0;
      else if (act1)    win = 1;
    end
    check_output("m0_ready", {31'b0, m0_ready}, {31'b0, win == 0});
    check_output("m1_ready", {31'b0, m1_ready}, {31'b0, win == 1});
    check_output("mem_we", {31'b0, mem_we}, {31'b0, have_txn && txn_we});
    if (have_txn) begin
      check_output("mem_addr", mem_addr, txn_addr);
      if (txn_we) check_output("mem_wdata", mem_wdata, txn_data);
    end
    check_output("m0_done", {31'b0, m0_done}, {31'b0, done_pend && cyc == done_cycle && done_id == 0});
    check_output("m1_done", {31'b0, m1_done}, {31'b0, done_pend && cyc == done_cycle && done_id == 1});
    check_output("m0_rdata", m0_rdata, exp_rdata[0]);
    check_output("m1_rdata", m1_rdata, exp_rdata[1]);
    if (done_pend && cyc == done_cycle) done_pend = 1'b0;
    if (have_txn) begin
      if (txn_we) model_mem[txn_addr[9:2]] = txn_data;
      else        done_val = model_mem[txn_addr[9:2]];
      done_rd    = !txn_we;
      done_pend  = 1'b1;
      done_cycle = cyc + 1;
      done_id    = txn_id;
      have_txn   = 1'b0;
    end
    if (win >= 0) begin
      have_txn  = 1'b1;
      txn_id    = win;
      txn_we    = pend_we[win];
      txn_addr  = pend_addr[win];
      txn_data  = pend_data[win];
      last      = (win == 1);
      pend[win] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_inputs();
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rand_mode = 1'b0;
    is_pdu    = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pend_we[i] = 1'b0; pend_addr[i] = '0; pend_data[i] = '0; keep[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[4]       = 32'hDEAD_BEEF;
    model_mem[4] = 32'hDEAD_BEEF;
    drive_inputs();
    #2;
    do_reset();

    $display("[TB] read of 0x10 by m1");
    apply_stimulus(1, 1'b0, 32'h10, 32'h0);
    run_cycles(4);
    check_output("read_0x10", m1_rdata, 32'hDEAD_BEEF);

    $display("[TB] continuous conflict from reset");
    do_reset();
    keep[0] = 1'b1;
    keep[1] = 1'b1;
    run_cycles(10);
    keep[0] = 1'b0;
    keep[1] = 1'b0;
    run_cycles(6);

    $display("[TB] PDU-exclusive mode");
    is_pdu  = 1'b1;
    keep[1] = 1'b1;
    apply_stimulus(0, 1'b0, 32'h44, 32'h0);
    run_cycles(10);
    is_pdu  = 1'b0;
    keep[1] = 1'b0;
    run_cycles(6);

    $display("[TB] write then read by m0");
    apply_stimulus(0, 1'b1, 32'h20, 32'h1234_5678);
    run_cycles(3);
    apply_stimulus(0, 1'b0, 32'h20, 32'h0);
    run_cycles(3);
    check_output("wr_rd_0x20", m0_rdata, 32'h1234_5678);

    $display("[TB] reset during a write access");
    run_cycles(2);
    apply_stimulus(0, 1'b1, 32'h40, 32'hA5A5_A5A5);
    run_cycle();
    rst = 1'b0;
    apply_stimulus(1, 1'b0, 32'h40, 32'h0);
    drive_inputs();
    #1;
    check_zero("rst_access");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b1;
    reset_model();
    run_cycles(4);
    check_output("aborted_write", m1_rdata, 32'h1000_0010);
    apply_stimulus(0, 1'b0, 32'h40, 32'h0);
    run_cycles(4);

    $display("[TB] randomized traffic");
    rand_mode = 1'b1;
    run_cycles(400);
    rand_mode = 1'b0;
    is_pdu    = 1'b0;
    run_cycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
